uart_cmd_rcv: RTL and testbench
===============================

// Module: uart_cmd_rcv
// PURPOSE
// UART receive front end for the command path: samples the host RX line (8N1, LSB first)
// and packs three consecutive bytes into a 24-bit command word. Holds cmd/cmd_rdy for the
// command dispatcher until the dispatcher pulses clr_cmd_rdy. Partial commands are dropped
// on inter-byte timeout or framing error.
// PARAMETERS
// BAUD_DIV    2604     clk cycles per bit (100 MHz / 38400); must be >= 16
// TIMEOUT     2000000  max idle clk cycles between bytes of one command before flushing
// PORTS
// clk          in   1   system clock
// rst_n        in   1   asynchronous active-low reset
// RX           in   1   asynchronous serial input, idle high
// clr_cmd_rdy  in   1   dispatcher accepted cmd; clears cmd_rdy next cycle
// cmd          out  24  assembled command {byte0, byte1, byte2}; byte0 = cmd[23:16]
// cmd_rdy      out  1   cmd valid; held until cleared
// frm_err      out  1   1-cycle pulse: stop bit sampled low
// overrun      out  1   1-cycle pulse: byte received while cmd_rdy = 1 (byte dropped)
// BEHAVIOUR
// - Reset (async): cmd = 0, cmd_rdy = 0, frm_err = 0, overrun = 0, byte count = 0,
//   RX FSM = IDLE, both sync flops preset to 1 (no false start after reset).
// - RX passes a 2-flop synchronizer; all decisions use the second flop (rx_s).
// - RX FSM: IDLE -> START on rx_s = 0; baud counter loaded with BAUD_DIV/2 - 1.
//   START: at terminal count, rx_s = 0 -> DATA (counter BAUD_DIV-1, bit idx 0);
//   rx_s = 1 -> IDLE (glitch rejected, no pulse).
//   DATA: at each terminal count shift rx_s into bit[idx], LSB first; after bit 7 -> STOP.
//   STOP: at terminal count, rx_s = 1 -> byte_vld pulse, IDLE; rx_s = 0 -> frm_err pulse,
//   byte discarded, byte count <- 0, wait in IDLE-equivalent until rx_s = 1 before re-arm.
// - Assembler on byte_vld with cmd_rdy = 0: count 0 -> cmd[23:16], 1 -> cmd[15:8],
//   2 -> cmd[7:0] and cmd_rdy <= 1 on the same edge, count wraps to 0.
//   cmd register updates only on accepted bytes; upper bytes may change before cmd_rdy.
// - byte_vld with cmd_rdy = 1 (including the cycle clr_cmd_rdy is high): byte dropped,
//   overrun pulse, count unchanged.
// - clr_cmd_rdy: cmd_rdy <= 0 next edge; cmd holds its value. clr with cmd_rdy = 0 is no-op.
//   Completion of byte 2 and clr cannot coincide (completion requires cmd_rdy = 0); if clr is
//   high on that edge, set wins.
// - Timeout counter: cleared on every accepted byte, runs while 0 < count < 3 and RX FSM
//   idle; reaching TIMEOUT sets count <- 0 (partial command flushed, no pulse).
// - Latency: cmd_rdy rises 1 clk after stop-bit mid-sample of byte 2 (+2 clk sync delay).
// - Reset mid-frame or mid-command: everything returns to reset state; next start bit begins
//   a fresh byte 0.
// - Width rules: baud counter $clog2(BAUD_DIV) bits, timeout counter $clog2(TIMEOUT+1) bits.
// TESTING
// 1 Send 0x02,0x05,0x1C at BAUD_DIV -> cmd_rdy = 1 with cmd = 24'h02051C; pulse clr ->
//   cmd_rdy = 0 next cycle, cmd stays 24'h02051C.
// 2 With cmd_rdy held (no clr) send 0xAA -> overrun pulses once, cmd unchanged; clr, then
//   send 0x08,0x12,0x34 -> cmd = 24'h081234.
// 3 Send 0x01, corrupt stop bit of next byte -> frm_err pulses; then 0x03,0x00,0x80 ->
//   cmd = 24'h030080 (partial 0x01 discarded).
// 4 Send 0x04,0x01 then idle TIMEOUT+10 clks, then 0x05,0x00,0x07 -> cmd = 24'h050007.
// 5 RX low pulse of BAUD_DIV/4 clks -> no byte, no pulses, count unchanged.
// 6 Assert rst_n low mid-bit of byte 1 -> all outputs 0; subsequent 3 bytes assemble cleanly.

Source files
------------

// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver that packs three bytes into a 24-bit command word,
// held with cmd_rdy_o until the dispatcher clears it.
module uart_cmd_rcv #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_i,
    input  logic        clr_cmd_rdy_i,
    output logic [23:0] cmd_o,
    output logic        cmd_rdy_o,
    output logic        frm_err_o,
    output logic        overrun_o
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TOUT = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [23:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    logic          frm_err_q, frm_err_d;
    logic          overrun_q, overrun_d;
    logic          tc, byte_vld, acc;

    always_comb begin
        tc        = baud_q == '0;
        byte_vld  = state_q == STOP && tc && rx_s_q;
        acc       = byte_vld && !cmd_rdy_q;
        state_d   = state_q;
        baud_d    = tc ? FULL : baud_q - BW'(1);
        idx_d     = idx_q;
        sh_d      = sh_q;
        frm_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    baud_d  = HALF;
                end
            end
            START: begin
                if (tc) begin
                    state_d = rx_s_q ? IDLE : DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tc) begin
                    sh_d    = {rx_s_q, sh_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    state_d = idx_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (tc) begin
                    state_d   = rx_s_q ? IDLE : WAIT_HI;
                    frm_err_d = !rx_s_q;
                end
            end
            default: state_d = rx_s_q ? IDLE : WAIT_HI;
        endcase
        overrun_d = byte_vld && cmd_rdy_q;
        cmd_d     = !acc ? cmd_q :
                    cnt_q == 2'd0 ? {sh_q, cmd_q[15:0]} :
                    cnt_q == 2'd1 ? {cmd_q[23:16], sh_q, cmd_q[7:0]} : {cmd_q[23:8], sh_q};
        cmd_rdy_d = (acc && cnt_q == 2'd2) || (cmd_rdy_q && !clr_cmd_rdy_i);
        cnt_d     = !acc ? cnt_q : cnt_q == 2'd2 ? 2'd0 : cnt_q + 2'd1;
        tout_d    = acc ? '0 : (cnt_q != 2'd0 && state_q == IDLE) ? tout_q + TW'(1) : tout_q;
        // A framing error or a stalled partial command restarts assembly at byte 0
        if (frm_err_d || tout_d == TOUT) begin
            cnt_d  = '0;
            tout_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            tout_q    <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            frm_err_q <= frm_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign cmd_o     = cmd_q;
    assign cmd_rdy_o = cmd_rdy_q;
    assign frm_err_o = frm_err_q;
    assign overrun_o = overrun_q;
endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb_uart_cmd_rcv: drives serial frames into uart_cmd_rcv and checks it against a
// byte-level command assembly model.
module tb_uart_cmd_rcv;
    localparam int BAUD = 16;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        clr = 1'b0;
    logic [23:0] cmd;
    logic        cmd_rdy, frm_err, overrun;

    uart_cmd_rcv #(.BAUD_DIV(BAUD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx), .clr_cmd_rdy_i(clr),
        .cmd_o(cmd), .cmd_rdy_o(cmd_rdy), .frm_err_o(frm_err), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic [7:0]  pend[$];
    logic [23:0] m_cmd = '0;
    logic        m_rdy = 1'b0;
    int          idle_acc = 0, exp_frm = 0, exp_ovr = 0, frm_seen = 0, ovr_seen = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        frm_seen += int'(frm_err);
        ovr_seen += int'(overrun);
        if (chk_en) begin
            check("cmd", {8'h0, cmd}, {8'h0, m_cmd});
            check("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, m_rdy});
        end
    end

    function automatic void m_reset();
        pend.delete();
        m_cmd    = '0;
        m_rdy    = 1'b0;
        idle_acc = 0;
    endfunction

    // Byte-level view: three accepted bytes make a command; anything arriving while one
    // is pending is an overrun; a bad stop bit throws away the partial command.
    function automatic void m_byte(input logic [7:0] b, input bit ok);
        int k;
        if (!ok) begin
            exp_frm++;
            pend.delete();
        end else if (m_rdy) begin
            exp_ovr++;
        end else begin
            pend.push_back(b);
            k = pend.size() - 1;
            m_cmd[23 - 8*k -: 8] = b;
            idle_acc = 0;
            if (pend.size() == 3) begin
                m_rdy = 1'b1;
                pend.delete();
            end
        end
    endfunction

    task automatic send(input logic [7:0] b, input bit ok = 1'b1, input int nbits = 10);
        logic [9:0] f;
        f = {ok, b, 1'b0};
        @(negedge clk);
        chk_en = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (BAUD) @(negedge clk);
        end
        if (nbits == 10) begin
            rx = 1'b1;
            repeat (2) @(negedge clk);
            m_byte(b, ok);
            check("frm_err pulses", frm_seen, exp_frm);
            check("overrun pulses", ovr_seen, exp_ovr);
            chk_en = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        idle_acc += n;
        if (pend.size() > 0 && idle_acc >= TO) begin
            pend.delete();
            idle_acc = 0;
        end
    endtask

    task automatic rnd_idle(input int n);
        idle(n);
        if (pend.size() > 0 && idle_acc > 100) idle(TO + 20);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        chk_en = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        m_rdy    = 1'b0;
        idle_acc += 2;
        chk_en   = 1'b1;
    endtask

    task automatic glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        rx = 1'b1;
        repeat (BAUD) @(negedge clk);
        idle_acc += BAUD / 4 + BAUD + 1;
        check("glitch frm_err", frm_seen, exp_frm);
        check("glitch overrun", ovr_seen, exp_ovr);
    endtask

    task automatic send3(input logic [23:0] c);
        send(c[23:16]);
        idle(5);
        send(c[15:8]);
        idle(5);
        send(c[7:0]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " cmd"}, {8'h0, cmd}, 32'h0);
        check({tag, " cmd_rdy"}, {31'h0, cmd_rdy}, 32'h0);
        check({tag, " frm_err"}, {31'h0, frm_err}, 32'h0);
        check({tag, " overrun"}, {31'h0, overrun}, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        m_reset();
        chk_en = 1'b1;
        idle(5);

        send3(24'h02051C);
        check("t1 cmd", {8'h0, cmd}, 32'h02051C);
        check("t1 rdy", {31'h0, cmd_rdy}, 32'h1);
        pulse_clr();
        check("t1 clr rdy", {31'h0, cmd_rdy}, 32'h0);
        check("t1 clr cmd", {8'h0, cmd}, 32'h02051C);

        send3(24'h010203);
        send(8'hAA);
        check("t2 overrun", ovr_seen, 1);
        check("t2 cmd held", {8'h0, cmd}, 32'h010203);
        pulse_clr();
        send3(24'h081234);
        check("t2 cmd", {8'h0, cmd}, 32'h081234);

        pulse_clr();
        send(8'h01);
        send(8'hC3, 1'b0);
        check("t3 frm_err", frm_seen, 1);
        idle(5);
        send3(24'h030080);
        check("t3 cmd", {8'h0, cmd}, 32'h030080);

        pulse_clr();
        send(8'h04);
        send(8'h01);
        idle(TO + 10);
        send3(24'h050007);
        check("t4 cmd", {8'h0, cmd}, 32'h050007);

        pulse_clr();
        send(8'h0A);
        idle(TO - 40);
        send(8'h0B);
        send(8'h0C);
        check("t4 no flush cmd", {8'h0, cmd}, 32'h0A0B0C);
        check("t4 no flush rdy", {31'h0, cmd_rdy}, 32'h1);

        pulse_clr();
        send(8'h11);
        glitch();
        send(8'h22);
        send(8'h33);
        check("t5 cmd", {8'h0, cmd}, 32'h112233);

        pulse_clr();
        send(8'h44);
        send(8'h55, 1'b1, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("t6 reset");
        rx = 1'b1;
        m_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        send3(24'h667788);
        check("t6 cmd", {8'h0, cmd}, 32'h667788);

        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5) send(8'($urandom));
            else if (op == 6) pulse_clr();
            else if (op == 7) glitch();
            else if (op == 8) send(8'($urandom), 1'b0);
            rnd_idle($urandom_range(0, 40));
        end
        check("final frm_err pulses", frm_seen, exp_frm);
        check("final overrun pulses", ovr_seen, exp_ovr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
